// File: rtl/morse_pkg.sv
// Shared types and constants for the Morse letter sequencer and its letter queue.
// Bit-unit timing is derived from the encoder clock setting via unit_cycles().
package morse_pkg;

  localparam int LETTER_W        = 3;
  localparam int BITS_PER_LETTER = 12;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    GAP  = 2'd3
  } seq_state_t;

  function automatic int unit_cycles(input int freq);
    return freq / 2 + 1;
  endfunction

endpackage

// File: rtl/morse_letter_fifo.sv
// Synchronous letter queue with push/pop, full/empty/count, sync reset and flush.
// DEPTH must be a power of two so the pointers wrap naturally.
module morse_letter_fifo
  import morse_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int WIDTH = LETTER_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       wdata,
  output logic [WIDTH-1:0]       rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign full    = (count_q == FULL_CNT);
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rdata   = mem_q[rd_ptr_q];
  // A push into a full queue is refused even when a pop frees a slot this cycle.
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + (AW+1)'(1);
        2'b01:   count_d = count_q - (AW+1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/morse_letter_sequencer.sv
// Feeds queued letter codes to the Morse encoder one at a time with inter-letter gaps.
// Define MORSE_SEQ_WATCHDOG_EN to abandon a letter whose encoder stops pulsing.
module morse_letter_sequencer
  import morse_pkg::*;
#(
  parameter int CLOCK_FREQUENCY = 500,
  parameter int DEPTH           = 8,
  parameter int GAP_UNITS       = 3
) (
  input  logic                   ClockIn,
  input  logic                   Reset,
  input  logic [LETTER_W-1:0]    LetterIn,
  input  logic                   LetterValid,
  output logic                   LetterReady,
  input  logic                   Abort,
  input  logic                   NewBitIn,
  output logic [LETTER_W-1:0]    LetterOut,
  output logic                   StartOut,
  output logic                   EncoderResetOut,
  output logic                   Busy,
  output logic                   LetterDone,
  output logic [$clog2(DEPTH):0] QueueCount,
  output logic                   Error
);

  localparam int UNIT_CYCLES = unit_cycles(CLOCK_FREQUENCY);
  localparam int GAP_TOTAL   = GAP_UNITS * UNIT_CYCLES;
  localparam int GW          = $clog2(GAP_TOTAL) + 1;
  localparam logic [GW-1:0] GAP_LOAD  = GW'(GAP_TOTAL - 1);
  localparam logic [3:0]    BITS_LAST = 4'(BITS_PER_LETTER - 1);

  seq_state_t          state_q, state_d;
  logic [LETTER_W-1:0] letter_q, letter_d;
  logic [3:0]          bit_cnt_q, bit_cnt_d;
  logic [GW-1:0]       gap_cnt_q, gap_cnt_d;
  logic                done_q, done_d;
  logic                enc_rst_q, enc_rst_d;

  logic                fifo_push, fifo_pop;
  logic [LETTER_W-1:0] fifo_rdata;
  logic                fifo_full, fifo_empty;

`ifdef MORSE_SEQ_WATCHDOG_EN
  localparam int SW = $clog2(2 * UNIT_CYCLES) + 1;
  localparam logic [SW-1:0] STALL_LAST = SW'(2 * UNIT_CYCLES - 1);
  logic [SW-1:0] stall_q, stall_d;
  logic          err_q, err_d;
`endif

  assign LetterReady = !fifo_full && !Abort && !Reset;
  assign fifo_push   = LetterValid && LetterReady;

  morse_letter_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (LETTER_W)
  ) u_fifo (
    .clk   (ClockIn),
    .rst   (Reset),
    .flush (Abort),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .wdata (LetterIn),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (QueueCount)
  );

  always_comb begin
    state_d   = state_q;
    letter_d  = letter_q;
    bit_cnt_d = bit_cnt_q;
    gap_cnt_d = gap_cnt_q;
    done_d    = 1'b0;
    enc_rst_d = 1'b0;
    fifo_pop  = 1'b0;
`ifdef MORSE_SEQ_WATCHDOG_EN
    stall_d   = stall_q;
    err_d     = 1'b0;
`endif
    if (Abort) begin
      state_d   = IDLE;
      bit_cnt_d = '0;
      gap_cnt_d = '0;
      enc_rst_d = 1'b1;
`ifdef MORSE_SEQ_WATCHDOG_EN
      stall_d   = '0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            letter_d = fifo_rdata;
            state_d  = LOAD;
          end
        end
        LOAD: begin
          bit_cnt_d = '0;
          state_d   = RUN;
`ifdef MORSE_SEQ_WATCHDOG_EN
          // Entering RUN counts as the first quiet cycle since the last event.
          stall_d   = SW'(1);
`endif
        end
        RUN: begin
          if (NewBitIn) begin
`ifdef MORSE_SEQ_WATCHDOG_EN
            stall_d = SW'(1);
`endif
            if (bit_cnt_q == BITS_LAST) begin
              done_d    = 1'b1;
              gap_cnt_d = GAP_LOAD;
              state_d   = GAP;
            end else begin
              bit_cnt_d = bit_cnt_q + 4'd1;
            end
          end
`ifdef MORSE_SEQ_WATCHDOG_EN
          else if (stall_q == STALL_LAST) begin
            err_d     = 1'b1;
            enc_rst_d = 1'b1;
            bit_cnt_d = '0;
            stall_d   = '0;
            state_d   = IDLE;
          end else begin
            stall_d = stall_q + SW'(1);
          end
`endif
        end
        GAP: begin
          if (gap_cnt_q == '0) begin
            if (!fifo_empty) begin
              fifo_pop = 1'b1;
              letter_d = fifo_rdata;
              state_d  = LOAD;
            end else begin
              state_d = IDLE;
            end
          end else begin
            gap_cnt_d = gap_cnt_q - GW'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge ClockIn) begin
    if (Reset) begin
      state_q   <= IDLE;
      letter_q  <= '0;
      bit_cnt_q <= '0;
      gap_cnt_q <= '0;
      done_q    <= 1'b0;
      enc_rst_q <= 1'b0;
`ifdef MORSE_SEQ_WATCHDOG_EN
      stall_q   <= '0;
      err_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      letter_q  <= letter_d;
      bit_cnt_q <= bit_cnt_d;
      gap_cnt_q <= gap_cnt_d;
      done_q    <= done_d;
      enc_rst_q <= enc_rst_d;
`ifdef MORSE_SEQ_WATCHDOG_EN
      stall_q   <= stall_d;
      err_q     <= err_d;
`endif
    end
  end

  assign LetterOut       = letter_q;
  assign StartOut        = (state_q == LOAD);
  assign Busy            = (state_q != IDLE);
  assign LetterDone      = done_q;
  assign EncoderResetOut = Reset | enc_rst_q;
`ifdef MORSE_SEQ_WATCHDOG_EN
  assign Error           = err_q;
`else
  assign Error           = 1'b0;
`endif

endmodule

// File: tb/tb_morse_letter_sequencer.sv
// Randomized bench with a stub encoder and a cycle-level timeline model of the sequencer.
module tb_morse_letter_sequencer;

  localparam int CF    = 10;
  localparam int DEPTH = 8;
  localparam int GAPU  = 3;
  localparam int U     = CF / 2 + 1;
  localparam int G     = GAPU * U;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [2:0]    lin = 3'd0;
  logic          lv = 1'b0;
  logic          abort = 1'b0;
  logic          nb = 1'b0;
  logic          LetterReady, StartOut, EncoderResetOut, Busy, LetterDone, Error;
  logic [2:0]    LetterOut;
  logic [CW-1:0] QueueCount;

  always #5 clk = ~clk;

  morse_letter_sequencer #(
    .CLOCK_FREQUENCY (CF),
    .DEPTH           (DEPTH),
    .GAP_UNITS       (GAPU)
  ) dut (
    .ClockIn         (clk),
    .Reset           (rst),
    .LetterIn        (lin),
    .LetterValid     (lv),
    .LetterReady     (LetterReady),
    .Abort           (abort),
    .NewBitIn        (nb),
    .LetterOut       (LetterOut),
    .StartOut        (StartOut),
    .EncoderResetOut (EncoderResetOut),
    .Busy            (Busy),
    .LetterDone      (LetterDone),
    .QueueCount      (QueueCount),
    .Error           (Error)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s: bound expired (cycle %0d)", name, cyc);
  endtask

  // Timeline model: letter queue, expected event cycles, and the expected Start codes.
  logic [2:0] mq[$];
  logic [2:0] sb[$];
  logic [2:0] m_letter = 3'd0;
  logic [2:0] cur = 3'd0;
  bit         busy_m = 1'b0;
  bit         busy_n;
  bit         running = 1'b0;
  bit         m_ready;
  int         pulses = 0;
  int         start_cyc = -1, done_cyc = -1, decide_cyc = -1;
  int         enc_rst_cyc = -1, err_cyc = -1, last_evt = -1;

  always @(negedge clk) begin
    m_ready = (mq.size() < DEPTH) && !abort && !rst;
    check("ready",  LetterReady, m_ready);
    check("start",  StartOut, cyc == start_cyc);
    check("busy",   Busy, busy_m);
    check("done",   LetterDone, cyc == done_cyc);
    check("qcount", QueueCount, mq.size());
    check("letter", LetterOut, m_letter);
    check("encrst", EncoderResetOut, rst || cyc == enc_rst_cyc || cyc == err_cyc);
    check("error",  Error, cyc == err_cyc);
    if (StartOut === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL start_code: StartOut with code %0d but no letter expected (cycle %0d)",
                 LetterOut, cyc);
      end else begin
        check("start_code", LetterOut, sb.pop_front());
      end
    end

    if (rst) begin
      mq.delete(); sb.delete();
      busy_m = 1'b0; running = 1'b0; m_letter = 3'd0;
      start_cyc = -1; done_cyc = -1; decide_cyc = -1; enc_rst_cyc = -1; err_cyc = -1;
    end else if (abort) begin
      mq.delete(); sb.delete();
      busy_m = 1'b0; running = 1'b0;
      start_cyc = -1; done_cyc = -1; decide_cyc = -1;
      enc_rst_cyc = cyc + 1;
    end else begin
      busy_n = busy_m;
      if (running && cyc > start_cyc) begin
        if (nb) begin
          pulses++;
          last_evt = cyc;
          if (pulses == 12) begin
            running    = 1'b0;
            done_cyc   = cyc + 1;
            decide_cyc = cyc + G;
          end
        end
`ifdef MORSE_SEQ_WATCHDOG_EN
        else if (cyc == last_evt + 2 * U - 1) begin
          running = 1'b0;
          err_cyc = cyc + 1;
          busy_n  = 1'b0;
        end
`endif
      end
      if (!busy_m || cyc == decide_cyc) begin
        if (mq.size() > 0) begin
          cur = mq.pop_front();
          sb.push_back(cur);
          m_letter  = cur;
          start_cyc = cyc + 1;
          busy_n    = 1'b1;
          running   = 1'b1;
          pulses    = 0;
          last_evt  = cyc + 1;
        end else begin
          busy_n = 1'b0;
        end
      end
      if (lv && m_ready) mq.push_back(lin);
      busy_m = busy_n;
    end
    cyc++;
  end

  // Stub encoder: 12 pulses per Start at random spacing, plus stray pulses when idle.
  bit silent = 1'b0;
  bit wd_stall = 1'b0;
  int pend = 0;
  int emitted = 0;

  initial begin
    forever begin
      @(negedge clk);
      if (StartOut === 1'b1) begin
        pend    = 12;
        emitted = 0;
      end
      @(posedge clk);
      #1;
      if (!silent && pend > 0 && $urandom_range(0, 2) != 0 && !(wd_stall && emitted >= 5)) begin
        nb = 1'b1;
        pend--;
        emitted++;
      end else begin
        nb = (pend == 0) && ($urandom_range(0, 15) == 0);
      end
    end
  end

  task automatic push_letter(input logic [2:0] c, input int bound, output bit ok);
    lin = c;
    lv  = 1'b1;
    ok  = 1'b0;
    for (int i = 0; i < bound && !ok; i++) begin
      @(negedge clk);
      ok = (LetterReady === 1'b1);
      @(posedge clk);
      #1;
    end
    lv = 1'b0;
  endtask

  task automatic wait_idle(input int bound, input string name);
    bit done_f = 1'b0;
    for (int i = 0; i < bound && !done_f; i++) begin
      @(negedge clk);
      if (Busy === 1'b0 && QueueCount == 0) done_f = 1'b1;
    end
    if (!done_f) fail_now(name);
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    bit ok;
    bit seen;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    idle_cycles(2);

    push_letter(3'd4, 5, ok);
    check("single_accept", ok, 1);
    wait_idle(400, "single_idle");

    for (int i = 0; i < 3; i++) begin
      push_letter(3'(i), 1, ok);
      check("b2b_accept", ok, 1);
    end
    wait_idle(600, "b2b_idle");

    silent = 1'b1;
    for (int i = 0; i < 9; i++) begin
      push_letter(3'(i % 8), 1, ok);
      check("fill_accept", ok, 1);
    end
    push_letter(3'd7, 4, ok);
    check("tenth_held", ok, 0);
    silent = 1'b0;
    push_letter(3'd7, 300, ok);
    check("tenth_after_pop", ok, 1);
    wait_idle(2000, "fill_idle");

    silent = 1'b1;
    push_letter(3'd3, 1, ok);
    push_letter(3'd5, 1, ok);
    push_letter(3'd6, 1, ok);
    push_letter(3'd1, 1, ok);
    idle_cycles(4);
    abort = 1'b1;
    idle_cycles(1);
    abort = 1'b0;
    silent = 1'b0;
    idle_cycles(40);
    wait_idle(50, "abort_idle");

    push_letter(3'd2, 5, ok);
    push_letter(3'd6, 5, ok);
    seen = 1'b0;
    for (int i = 0; i < 400 && !seen; i++) begin
      @(negedge clk);
      seen = (LetterDone === 1'b1);
    end
    if (!seen) fail_now("wait_done");
    idle_cycles(4);
    rst = 1'b1;
    idle_cycles(2);
    rst = 1'b0;
    idle_cycles(30);
    wait_idle(50, "reset_idle");

`ifdef MORSE_SEQ_WATCHDOG_EN
    wd_stall = 1'b1;
    push_letter(3'd5, 5, ok);
    push_letter(3'd1, 5, ok);
    wait_idle(600, "watchdog_idle");
    wd_stall = 1'b0;
`endif

    for (int i = 0; i < 3000; i++) begin
      lv    = (i < 1500) ? ($urandom_range(0, 24) == 0) : ($urandom_range(0, 1) == 1);
      lin   = 3'($urandom_range(0, 7));
      abort = ($urandom_range(0, 399) == 0);
      idle_cycles(1);
    end
    lv    = 1'b0;
    abort = 1'b0;
    wait_idle(3000, "random_idle");

    abort = 1'b1;
    idle_cycles(1);
    abort = 1'b0;
    idle_cycles(4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "global timeout");
  end

endmodule
